// File: rtl/wb_port_arbiter_pkg.sv
// Shared pipeline write-port types and constants, reused by MEM/WB, EX/MEM
// and the writeback arbiter.
package wb_port_arbiter_pkg;

    localparam int PIPE_DW = 32;
    localparam int PIPE_AW = 5;

    localparam logic [PIPE_AW-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic               we;
        logic [PIPE_AW-1:0] addr;
        logic [PIPE_DW-1:0] data;
    } wb_req_t;

    // True when a source register is real (not $0) and names the destination.
    function automatic logic addr_hits(input logic [PIPE_AW-1:0] src,
                                       input logic [PIPE_AW-1:0] dst);
        return (src != REG_ZERO) && (src == dst);
    endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bus bundle between the pipeline/multi-cycle unit side (master) and the
// writeback-port arbiter (slave).
interface wb_port_arbiter_if #(
    parameter int DW = wb_port_arbiter_pkg::PIPE_DW,
    parameter int AW = wb_port_arbiter_pkg::PIPE_AW
);
    logic          pipe_wr_en;
    logic [AW-1:0] pipe_wr_addr;
    logic [DW-1:0] pipe_wr_data;
    logic          mc_valid;
    logic [AW-1:0] mc_addr;
    logic [DW-1:0] mc_data;
    logic          mc_ready;
    logic [AW-1:0] rs_addr;
    logic [AW-1:0] rt_addr;
    logic          raw_hazard;
    logic          stall_req;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;

    modport master (
        output pipe_wr_en, pipe_wr_addr, pipe_wr_data,
        output mc_valid, mc_addr, mc_data,
        output rs_addr, rt_addr,
        input  mc_ready, raw_hazard, stall_req,
        input  rf_we, rf_waddr, rf_wdata
    );

    modport slave (
        input  pipe_wr_en, pipe_wr_addr, pipe_wr_data,
        input  mc_valid, mc_addr, mc_data,
        input  rs_addr, rt_addr,
        output mc_ready, raw_hazard, stall_req,
        output rf_we, rf_waddr, rf_wdata
    );
endinterface

// File: rtl/wb_port_arbiter_fifo.sv
// Multi-cycle result buffer: storage, wrap-around pointers, occupancy count
// and a live bit per entry. Entries whose address is overwritten by a younger
// pipeline write are squashed (live cleared) but still occupy their slot
// until popped.
module wb_port_arbiter_fifo
    import wb_port_arbiter_pkg::*;
#(
    parameter int DW    = PIPE_DW,
    parameter int AW    = PIPE_AW,
    parameter int DEPTH = 2
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     push_en,
    input  logic [AW-1:0]            push_addr,
    input  logic [DW-1:0]            push_data,
    input  logic                     push_live,
    input  logic                     pop_en,
    input  logic                     squash_en,
    input  logic [AW-1:0]            squash_addr,
    output logic                     full,
    output logic                     empty,
    output logic [AW-1:0]            head_addr,
    output logic [DW-1:0]            head_data,
    output logic                     head_live,
    output logic [DEPTH-1:0][AW-1:0] entry_addr,
    output logic [DEPTH-1:0]         entry_live
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0][AW-1:0] addr_r;
    logic [DEPTH-1:0][DW-1:0] data_r;
    logic [DEPTH-1:0]         live_r;
    logic [DEPTH-1:0]         live_s;
    logic [PW-1:0]            rd_ptr_r;
    logic [PW-1:0]            wr_ptr_r;
    logic [CW-1:0]            count_r;

    // Next live bits: a push sets the written slot, a pop or a matching squash clears one.
    always_comb begin
        live_s = live_r;
        for (int i = 0; i < DEPTH; i++) begin
            live_s[i] = (push_en && (PW'(i) == wr_ptr_r)) ? push_live :
                        ((pop_en && (PW'(i) == rd_ptr_r)) ||
                         (squash_en && (addr_r[i] == squash_addr))) ? 1'b0 : live_r[i];
        end
    end

    // Storage, pointers and occupancy count.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            addr_r   <= '{default: {AW{1'b0}}};
            data_r   <= '{default: {DW{1'b0}}};
            live_r   <= {DEPTH{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            wr_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            live_r <= live_s;
            if (push_en) begin
                addr_r[wr_ptr_r] <= push_addr;
                data_r[wr_ptr_r] <= push_data;
                wr_ptr_r         <= wr_ptr_r + PW'(1);
            end
            if (pop_en) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_en, pop_en})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign full       = (count_r == CW'(DEPTH));
    assign empty      = (count_r == CW'(0));
    assign head_addr  = addr_r[rd_ptr_r];
    assign head_data  = data_r[rd_ptr_r];
    assign head_live  = live_r[rd_ptr_r];
    assign entry_addr = addr_r;
    assign entry_live = live_r;

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter between MEM/WB and the mult/div unit.
// Multi-cycle results are buffered and drained into idle writeback slots;
// buffered destinations raise a RAW hazard and are squashed by younger
// pipeline writes to the same register.
// Optional build macro WB_ARB_FAIRNESS_EN: a head denied STARVE_LIMIT times
// forces a one-cycle pipeline stall so it can be written.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int DW    = PIPE_DW,
    parameter int AW    = PIPE_AW,
    parameter int DEPTH = 2
`ifdef WB_ARB_FAIRNESS_EN
   ,parameter int STARVE_LIMIT = 4
`endif
) (
    input  logic               Clk,
    input  logic               Rst,
    wb_port_arbiter_if.slave   bus
);
    logic                     full_s;
    logic                     empty_s;
    logic [AW-1:0]            head_addr_s;
    logic [DW-1:0]            head_data_s;
    logic                     head_live_s;
    logic [DEPTH-1:0][AW-1:0] entry_addr_s;
    logic [DEPTH-1:0]         entry_live_s;
    logic                     pipe_grant_s;
    logic                     head_grant_s;
    logic                     pop_s;
    logic                     push_s;
    logic                     push_live_s;
    logic                     stall_s;
    logic                     raw_hazard_s;
    logic                     rf_we_r;
    logic [AW-1:0]            rf_waddr_r;
    logic [DW-1:0]            rf_wdata_r;
    logic                     mc_wb_r;

    wb_port_arbiter_fifo #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) u_fifo (
        .Clk         (Clk),
        .Rst         (Rst),
        .push_en     (push_s),
        .push_addr   (bus.mc_addr),
        .push_data   (bus.mc_data),
        .push_live   (push_live_s),
        .pop_en      (pop_s),
        .squash_en   (pipe_grant_s),
        .squash_addr (bus.pipe_wr_addr),
        .full        (full_s),
        .empty       (empty_s),
        .head_addr   (head_addr_s),
        .head_data   (head_data_s),
        .head_live   (head_live_s),
        .entry_addr  (entry_addr_s),
        .entry_live  (entry_live_s)
    );

    // Grant the pipeline unless stalled; otherwise drain the live head. Dead heads pop for free.
    always_comb begin
        pipe_grant_s = bus.pipe_wr_en && (bus.pipe_wr_addr != REG_ZERO) && !stall_s;
        head_grant_s = head_live_s && !pipe_grant_s;
        pop_s        = !empty_s && (!head_live_s || head_grant_s);
        push_s       = bus.mc_valid && !full_s;
        // A result to $0, or one overwritten by the younger pipeline write this cycle, enters dead.
        push_live_s  = (bus.mc_addr != REG_ZERO) &&
                       !(pipe_grant_s && (bus.mc_addr == bus.pipe_wr_addr));
    end

    // Registered write-port drive; remembers whether the write came from the buffer.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            rf_we_r    <= 1'b0;
            rf_waddr_r <= {AW{1'b0}};
            rf_wdata_r <= {DW{1'b0}};
            mc_wb_r    <= 1'b0;
        end else if (pipe_grant_s) begin
            rf_we_r    <= 1'b1;
            rf_waddr_r <= bus.pipe_wr_addr;
            rf_wdata_r <= bus.pipe_wr_data;
            mc_wb_r    <= 1'b0;
        end else if (head_grant_s) begin
            rf_we_r    <= 1'b1;
            rf_waddr_r <= head_addr_s;
            rf_wdata_r <= head_data_s;
            mc_wb_r    <= 1'b1;
        end else begin
            rf_we_r    <= 1'b0;
            rf_waddr_r <= {AW{1'b0}};
            rf_wdata_r <= {DW{1'b0}};
            mc_wb_r    <= 1'b0;
        end
    end

    // RAW hazard: live buffered entries, plus a buffered result still on the write port this cycle.
    always_comb begin
        raw_hazard_s = rf_we_r && mc_wb_r &&
                       (addr_hits(bus.rs_addr, rf_waddr_r) || addr_hits(bus.rt_addr, rf_waddr_r));
        for (int i = 0; i < DEPTH; i++) begin
            raw_hazard_s = raw_hazard_s ||
                           (entry_live_s[i] && (addr_hits(bus.rs_addr, entry_addr_s[i]) ||
                                                addr_hits(bus.rt_addr, entry_addr_s[i])));
        end
    end

`ifdef WB_ARB_FAIRNESS_EN
    localparam int WCW = $clog2(STARVE_LIMIT + 1);

    logic [WCW-1:0] wait_cnt_r;
    logic [WCW-1:0] wait_cnt_s;
    logic           stall_req_r;

    // Count consecutive denials of a live head, saturating at the starvation limit.
    always_comb begin
        if (empty_s || !head_live_s || head_grant_s) begin
            wait_cnt_s = WCW'(0);
        end else if (wait_cnt_r < WCW'(STARVE_LIMIT)) begin
            wait_cnt_s = wait_cnt_r + WCW'(1);
        end else begin
            wait_cnt_s = wait_cnt_r;
        end
    end

    // Wait counter and the one-cycle stall that hands the slot to a starved head.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            wait_cnt_r  <= WCW'(0);
            stall_req_r <= 1'b0;
        end else begin
            wait_cnt_r  <= wait_cnt_s;
            stall_req_r <= bus.pipe_wr_en && head_live_s && !head_grant_s && !stall_req_r &&
                           (wait_cnt_s == WCW'(STARVE_LIMIT));
        end
    end

    assign stall_s = stall_req_r;
`else
    assign stall_s = 1'b0;
`endif

    assign bus.mc_ready   = !full_s;
    assign bus.raw_hazard = raw_hazard_s;
    assign bus.stall_req  = stall_s;
    assign bus.rf_we      = rf_we_r;
    assign bus.rf_waddr   = rf_waddr_r;
    assign bus.rf_wdata   = rf_wdata_r;

endmodule
